// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack controller: opcodes and FSM states.
package rpn_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    POP_A  = 2'b01,
    PUSH_R = 2'b10,
    DONE   = 2'b11
  } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN controller: y = a op b, modulo 2^WIDTH.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Postfix evaluation controller driving an external push/pop stack; tracks
// depth itself and flags overflow/underflow with a sticky error bit.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         tok_valid,
  output logic                         tok_ready,
  input  logic                         tok_is_op,
  input  logic [WIDTH-1:0]             tok_data,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [WIDTH-1:0]             stk_data_in,
  input  logic [WIDTH-1:0]             stk_data_out,
  output logic [WIDTH-1:0]             result,
  output logic                         res_valid,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         error
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_TWO = DW'(2);

  state_t           state, state_n;
  logic [DW-1:0]    depth_n;
  logic             error_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
  opcode_t          op_q, op_n;
  logic [WIDTH-1:0] alu_y;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  assign result = (depth == '0) ? '0 : stk_data_out;

  // Handshake and stack strobes are gated by reset so nothing leaks out
  // while the stack and this block are being cleared.
  always_comb begin
    state_n     = state;
    depth_n     = depth;
    error_n     = error;
    a_n         = a_q;
    b_n         = b_q;
    op_n        = op_q;
    tok_ready   = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    res_valid   = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          tok_ready = 1'b1;
          if (tok_valid) begin
            if (!tok_is_op) begin
              if (depth != DEPTH_MAX) begin
                stk_push    = 1'b1;
                stk_data_in = tok_data;
                depth_n     = depth + 1'b1;
              end else begin
                error_n = 1'b1;
              end
            end else if (depth >= DEPTH_TWO) begin
              b_n     = stk_data_out;
              op_n    = opcode_t'(tok_data[1:0]);
              stk_pop = 1'b1;
              depth_n = depth - 1'b1;
              state_n = POP_A;
            end else begin
              error_n = 1'b1;
            end
          end
        end
        POP_A: begin
          a_n     = stk_data_out;
          stk_pop = 1'b1;
          depth_n = depth - 1'b1;
          state_n = PUSH_R;
        end
        PUSH_R: begin
          stk_push    = 1'b1;
          stk_data_in = alu_y;
          depth_n     = depth + 1'b1;
          state_n     = DONE;
        end
        DONE: begin
          res_valid = 1'b1;
          state_n   = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      depth <= '0;
      error <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_ADD;
    end else begin
      state <= state_n;
      depth <= depth_n;
      error <= error_n;
      a_q   <= a_n;
      b_q   <= b_n;
      op_q  <= op_n;
    end
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Self-checking bench: controller plus a behavioural stack, compared every
// cycle against a queue-based model of the RPN evaluation rules.
module tb_rpn_stack_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             tok_valid = 1'b0;
  logic             tok_ready;
  logic             tok_is_op = 1'b0;
  logic [WIDTH-1:0] tok_data = '0;
  logic             stk_push, stk_pop;
  logic [WIDTH-1:0] stk_data_in, stk_data_out;
  logic [WIDTH-1:0] result;
  logic             res_valid;
  logic [4:0]       depth;
  logic             error;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rpn_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_is_op    (tok_is_op),
    .tok_data     (tok_data),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .result       (result),
    .res_valid    (res_valid),
    .depth        (depth),
    .error        (error)
  );

  // Attached stack: synchronous push/pop, combinational top, shared reset.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [4:0]       sp;
  always @(posedge clock) begin
    if (!reset) sp <= '0;
    else if (stk_push && sp < 5'(DEPTH)) begin
      mem[sp] <= stk_data_in;
      sp      <= sp + 5'd1;
    end else if (stk_pop && sp != '0) sp <= sp - 5'd1;
  end
  assign stk_data_out = (sp == '0) ? '0 : mem[sp - 5'd1];

  // Reference model: a queue holds stack contents; busy counts the cycles
  // an operator occupies after acceptance (pop a, push result, done).
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_a, m_b;
  logic [1:0]       m_op;
  int               busy = 0;
  bit               m_err = 0;
  bit               m_acc = 0;
  bit               cmp_en = 0;

  function automatic logic [WIDTH-1:0] calc(input logic [WIDTH-1:0] a, b, input logic [1:0] op);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      mq.delete();
      busy   = 0;
      m_err  = 0;
      cmp_en = 1;
    end else if (busy > 0) begin
      if (busy == 3) m_a = mq.pop_back();
      if (busy == 2) mq.push_back(calc(m_a, m_b, m_op));
      busy--;
    end else if (tok_valid) begin
      m_acc = 1;
      if (!tok_is_op) begin
        if (mq.size() < DEPTH) mq.push_back(tok_data);
        else m_err = 1;
      end else if (mq.size() >= 2) begin
        m_b  = mq.pop_back();
        m_op = tok_data[1:0];
        busy = 3;
      end else m_err = 1;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("tok_ready", int'(tok_ready), int'(reset && busy == 0));
      chk("res_valid", int'(res_valid), int'(reset && busy == 1));
      chk("depth", int'(depth), mq.size());
      chk("result", int'(result), (mq.size() == 0) ? 0 : int'(mq[$]));
      chk("error", int'(error), int'(m_err));
      chk("push_pop_excl", int'(stk_push && stk_pop), 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input bit is_op, input logic [WIDTH-1:0] data);
    bit done;
    done      = 0;
    tok_is_op = is_op;
    tok_data  = data;
    tok_valid = 1'b1;
    m_acc     = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (m_acc) done = 1;
    end
    tok_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    do_reset();
    chk("lit_reset_depth", int'(depth), 0);
    chk("lit_reset_ready", int'(tok_ready), 1);

    // 3 4 ADD -> 7
    send(0, 8'd3);
    send(0, 8'd4);
    send(1, 8'd0);
    tick();
    tick();
    chk("lit_add_rv", int'(res_valid), 1);
    chk("lit_add_result", int'(result), 8'h07);
    chk("lit_add_depth", int'(depth), 1);
    tick();
    chk("lit_add_rv_pulse", int'(res_valid), 0);
    chk("lit_add_error", int'(error), 0);

    // 2 5 SUB -> 0xFD
    do_reset();
    send(0, 8'd2);
    send(0, 8'd5);
    send(1, 8'd1);
    repeat (3) tick();
    chk("lit_sub_result", int'(result), 8'hFD);
    chk("lit_sub_depth", int'(depth), 1);

    // F0 3C 0F AND XOR -> 0C then FC; XOR is held valid while busy
    do_reset();
    send(0, 8'hF0);
    send(0, 8'h3C);
    send(0, 8'h0F);
    send(1, 8'd2);
    send(1, 8'd3);
    chk("lit_and_top_pending", int'(depth), 1);
    tick();
    tick();
    chk("lit_xor_result", int'(result), 8'hFC);
    tick();

    // Underflow then recovery
    do_reset();
    send(0, 8'd1);
    send(1, 8'd0);
    chk("lit_uf_error", int'(error), 1);
    chk("lit_uf_depth", int'(depth), 1);
    chk("lit_uf_result", int'(result), 1);
    send(0, 8'd1);
    send(1, 8'd0);
    repeat (3) tick();
    chk("lit_uf_recover", int'(result), 2);

    // Overflow: 17th operand dropped
    do_reset();
    for (int v = 1; v <= 17; v++) send(0, 8'(v));
    chk("lit_of_depth", int'(depth), 16);
    chk("lit_of_top", int'(result), 16);
    chk("lit_of_error", int'(error), 1);

    // Reset during POP_A
    send(1, 8'd0);
    chk("lit_popa_ready", int'(tok_ready), 0);
    reset = 1'b0;
    tick();
    chk("lit_rst_depth", int'(depth), 0);
    chk("lit_rst_ready_low", int'(tok_ready), 0);
    chk("lit_rst_error", int'(error), 0);
    reset = 1'b1;
    tick();
    chk("lit_rst_ready_high", int'(tok_ready), 1);
    send(0, 8'd9);
    send(0, 8'd6);
    send(1, 8'd3);
    repeat (3) tick();
    chk("lit_post_rst_xor", int'(result), 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rpn_stack_ctrl.md
# rpn_stack_ctrl

Postfix (RPN) evaluation controller that drives the 8-bit push/pop stack directly from a token stream. It accepts operand and operator tokens over a valid/ready handshake. Operands become pushes; each operator becomes pop–pop–compute–push. The block tracks stack depth itself, because the stack exposes no full/empty flags, and it flags overflow and underflow. It sits directly upstream of the stack: `stk_*` outputs connect to the stack's `push`, `pop` and `data_in`, and `stk_data_out` connects to the stack's `data_out`.

## Interface
- `WIDTH`, 8: token and stack data width.
- `DEPTH`, 16: stack capacity in entries; must equal the attached stack's depth.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `tok_valid`  in  1  token present.
- `tok_ready`  out  1  block accepts a token this cycle.
- `tok_is_op`  in  1  1 = operator, 0 = operand.
- `tok_data`  in  WIDTH  operand value, or opcode in bits [1:0].
- `stk_push`  out  1  to stack `push`.
- `stk_pop`  out  1  to stack `pop`.
- `stk_data_in`  out  WIDTH  to stack `data_in`.
- `stk_data_out`  in  WIDTH  from stack `data_out` (current top of stack).
- `result`  out  WIDTH  current top of stack; 0 when depth = 0.
- `res_valid`  out  1  one-cycle pulse when an operator result is visible on `result`.
- `depth`  out  clog2(DEPTH+1)  current entry count.
- `error`  out  1  sticky overflow/underflow flag.

## Operation
- Stack contract:
  - `stk_data_out` is the top of stack, combinationally.
  - Push and pop take effect at the rising edge.
  - The stack shares `clock` and `reset` with this block.
  - This block never asserts `stk_push` and `stk_pop` in the same cycle.
- Opcodes in `tok_data[1:0]`: 00 ADD, 01 SUB, 10 AND, 11 XOR.
- Operands: `a` is the deeper entry, `b` is the top. Result = `a` op `b`, mod 2^WIDTH. SUB is `a` − `b` with wrap.
- FSM states: IDLE, POP_A, PUSH_R, DONE.
- IDLE:
  - `tok_ready` = 1. A transfer occurs when `tok_valid` & `tok_ready`.
  - Operand, `depth` < DEPTH: `stk_push` = 1, `stk_data_in` = `tok_data`, `depth` +1. Stay in IDLE.
  - Operand, `depth` = DEPTH: token consumed and dropped, no push, `error` set.
  - Operator, `depth` ≥ 2: latch `b` = `stk_data_out` and the opcode, `stk_pop` = 1, `depth` −1. Go to POP_A.
  - Operator, `depth` < 2: token consumed, no stack activity, `error` set. Stay in IDLE.
- POP_A: `tok_ready` = 0. Latch `a` = `stk_data_out`, `stk_pop` = 1, `depth` −1. Go to PUSH_R.
- PUSH_R: `tok_ready` = 0. `stk_data_in` = ALU(`a`, `b`, op), `stk_push` = 1, `depth` +1. Go to DONE.
- DONE: `tok_ready` = 0, `res_valid` = 1. Go to IDLE.
- `error` is set only by the two IDLE conditions above and is cleared only by reset. Processing continues normally after an error.

## Timing
- Reset (`reset` = 0 at a rising edge):
  - State ← IDLE, `depth` ← 0, `error` ← 0, latches ← 0.
  - While `reset` = 0: `tok_ready`, `stk_push`, `stk_pop`, `res_valid` forced 0; `stk_data_in` forced 0.
- Reset asserted mid-operator abandons the operation. The stack resets in the same edge, so no partial state survives.
- Operand: 1 cycle, back-to-back operands at full rate.
- Operator: 4 cycles from acceptance to the next `tok_ready`. `res_valid` is high in DONE, when `result` already equals the pushed value.
- `stk_push`, `stk_pop` and `stk_data_in` are combinational from state and token.
- `depth` and `res_valid` are registered or state-decoded.
- Overflow or underflow tokens take 1 cycle; `error` is visible the next cycle.

## Structure
- Shared package/include `rpn_pkg`: opcode constants (OP_ADD, OP_SUB, OP_AND, OP_XOR) and FSM state encodings.
- Sub-module `rpn_alu`: combinational, inputs `a`, `b`, op, output WIDTH-bit result.
- Top level holds the FSM, depth counter, operand latches and error flag.
- Bench instantiates `rpn_stack_ctrl` together with the real stack.

## Test plan
- Reset, then push 3 and 4, then ADD → `result` = 7 with one-cycle `res_valid`, `depth` = 1, `error` = 0.
- Push 2 and 5, then SUB → `result` = 0xFD (wrap), `depth` = 1.
- Push 0xF0, 0x3C, 0x0F, then AND, then XOR → intermediate top 0x0C, final `result` = 0xFC, `depth` = 1.
- Push 1, then ADD → `error` = 1, `depth` stays 1, `result` = 1. A following push 1 + ADD still gives 2.
- Push 17 operands with DEPTH = 16 → 17th dropped, `error` = 1, `depth` = 16, top = 16th value.
- Assert reset during POP_A → next cycle `depth` = 0, `tok_ready` = 0 while reset is low, then 1; `error` = 0.
